// File: rtl/qcm_cal_sequencer.sv
// qcm_cal_sequencer: capacitor-code calibration sweep with settle, n_clk averaging and result handshake.
// Normal mode passes lut_state/lut_enable through one register stage.
module qcm_cal_sequencer #(
  parameter int CODE_W     = 7,
  parameter int NCLK_W     = 14,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 64,
  parameter int AVG_LOG2   = 2
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_cal_start,
  input  logic              i_cal_abort,
  input  logic [CODE_W-1:0] i_code_first,
  input  logic [CODE_W-1:0] i_code_last,
  input  logic [DWELL_W-1:0] i_dwell_cycles,
  input  logic [CODE_W-1:0] i_lut_state,
  input  logic              i_lut_enable,
  input  logic [NCLK_W-1:0] i_n_clk,
  output logic [CODE_W-1:0] o_code_out,
  output logic              o_enable_out,
  output logic              o_busy,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [CODE_W-1:0] o_result_code,
  output logic [NCLK_W-1:0] o_result_nclk,
  output logic              o_done,
  output logic              o_aborted
);
  localparam int ACC_W = NCLK_W + AVG_LOG2;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int SMP_W = AVG_LOG2 + 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_REPORT} state_t;
  state_t r_state, w_state_nxt;
  logic [CODE_W-1:0]  r_code, w_code_nxt, r_code_last, r_res_code, w_res_code_nxt;
  logic               r_enable, w_enable_nxt, r_down, r_valid, w_valid_nxt;
  logic               r_done, w_done_nxt, r_aborted, w_aborted_nxt;
  logic [DWELL_W-1:0] r_dwell, r_dwell_cnt, w_dwell_cnt_nxt;
  logic [SET_W-1:0]   r_settle_cnt, w_settle_cnt_nxt;
  logic [SMP_W-1:0]   r_samp_cnt, w_samp_cnt_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt, w_sum;
  logic [NCLK_W-1:0]  r_res_nclk, w_res_nclk_nxt;
  logic               w_start;
  assign w_start = (r_state == S_IDLE) && i_cal_start && !i_cal_abort;
  assign w_sum   = r_acc + ACC_W'(i_n_clk);
  always_comb begin
    w_state_nxt      = r_state;
    w_code_nxt       = r_code;
    w_enable_nxt     = r_enable;
    w_valid_nxt      = r_valid;
    w_res_code_nxt   = r_res_code;
    w_res_nclk_nxt   = r_res_nclk;
    w_done_nxt       = 1'b0;
    w_aborted_nxt    = 1'b0;
    w_settle_cnt_nxt = r_settle_cnt;
    w_dwell_cnt_nxt  = r_dwell_cnt;
    w_samp_cnt_nxt   = r_samp_cnt;
    w_acc_nxt        = r_acc;
    case (r_state)
      S_IDLE: begin
        w_code_nxt   = w_start ? i_code_first : i_lut_state;
        w_enable_nxt = w_start ? 1'b0 : i_lut_enable;
        w_state_nxt  = w_start ? S_SETTLE : S_IDLE;
        w_settle_cnt_nxt = '0;
      end
      S_SETTLE: begin
        w_settle_cnt_nxt = r_settle_cnt + SET_W'(1);
        if (r_settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          w_state_nxt     = S_ACCUM;
          w_enable_nxt    = 1'b1;
          w_acc_nxt       = '0;
          w_samp_cnt_nxt  = '0;
          w_dwell_cnt_nxt = '0;
        end
      end
      S_ACCUM: begin
        w_dwell_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
        if (r_dwell_cnt == r_dwell - DWELL_W'(1)) begin
          w_dwell_cnt_nxt = '0;
          w_acc_nxt       = w_sum;
          w_samp_cnt_nxt  = r_samp_cnt + SMP_W'(1);
          // The final sample is folded in directly so the result is ready on entry to REPORT.
          if (r_samp_cnt == SMP_W'((1 << AVG_LOG2) - 1)) begin
            w_state_nxt    = S_REPORT;
            w_valid_nxt    = 1'b1;
            w_res_code_nxt = r_code;
            w_res_nclk_nxt = NCLK_W'(w_sum >> AVG_LOG2);
          end
        end
      end
      S_REPORT: begin
        if (i_result_ready) begin
          w_valid_nxt = 1'b0;
          if (r_code == r_code_last) begin
            w_state_nxt  = S_IDLE;
            w_done_nxt   = 1'b1;
            w_code_nxt   = i_lut_state;
            w_enable_nxt = i_lut_enable;
          end else begin
            w_state_nxt      = S_SETTLE;
            w_code_nxt       = r_down ? r_code - CODE_W'(1) : r_code + CODE_W'(1);
            w_enable_nxt     = 1'b0;
            w_settle_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_cal_abort && r_state != S_IDLE) begin
      w_state_nxt   = S_IDLE;
      w_valid_nxt   = 1'b0;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b1;
      w_code_nxt    = i_lut_state;
      w_enable_nxt  = i_lut_enable;
    end
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_enable     <= 1'b0;
      r_valid      <= 1'b0;
      r_res_code   <= '0;
      r_res_nclk   <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_settle_cnt <= '0;
      r_dwell_cnt  <= '0;
      r_samp_cnt   <= '0;
      r_acc        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_code       <= w_code_nxt;
      r_enable     <= w_enable_nxt;
      r_valid      <= w_valid_nxt;
      r_res_code   <= w_res_code_nxt;
      r_res_nclk   <= w_res_nclk_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_dwell_cnt  <= w_dwell_cnt_nxt;
      r_samp_cnt   <= w_samp_cnt_nxt;
      r_acc        <= w_acc_nxt;
    end
  end
  // Sweep parameters are captured only on an accepted start.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_code_last <= '0;
      r_dwell     <= '0;
      r_down      <= 1'b0;
    end else if (w_start) begin
      r_code_last <= i_code_last;
      r_dwell     <= (i_dwell_cycles == '0) ? DWELL_W'(1) : i_dwell_cycles;
      r_down      <= i_code_first > i_code_last;
    end
  end
  assign o_code_out     = r_code;
  assign o_enable_out   = r_enable;
  assign o_busy         = r_state != S_IDLE;
  assign o_result_valid = r_valid;
  assign o_result_code  = r_res_code;
  assign o_result_nclk  = r_res_nclk;
  assign o_done         = r_done;
  assign o_aborted      = r_aborted;
endmodule

// File: tb/tb_qcm_cal_sequencer.sv
// tb_qcm_cal_sequencer: directed scenario tests for the calibration sequencer.
module tb_qcm_cal_sequencer;
  logic        clk = 1'b0, nrst = 1'b0, cal_start = 1'b0, cal_abort = 1'b0;
  logic [6:0]  code_first = '0, code_last = '0, lut_state = '0;
  logic [15:0] dwell_cycles = '0;
  logic        lut_enable = 1'b0, result_ready = 1'b0;
  logic [13:0] n_clk = '0;
  logic [6:0]  code_out, result_code;
  logic        enable_out, busy, result_valid, done, aborted;
  logic [13:0] result_nclk;
  int vectors = 0, miscompares = 0;

  qcm_cal_sequencer #(.CODE_W(7), .NCLK_W(14), .DWELL_W(16), .SETTLE_CYC(64), .AVG_LOG2(2)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_cal_start(cal_start), .i_cal_abort(cal_abort),
    .i_code_first(code_first), .i_code_last(code_last), .i_dwell_cycles(dwell_cycles),
    .i_lut_state(lut_state), .i_lut_enable(lut_enable), .i_n_clk(n_clk),
    .o_code_out(code_out), .o_enable_out(enable_out), .o_busy(busy),
    .o_result_valid(result_valid), .i_result_ready(result_ready),
    .o_result_code(result_code), .o_result_nclk(result_nclk),
    .o_done(done), .o_aborted(aborted));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      lut_state = 7'($urandom); lut_enable = 1'b1; cal_start = 1'($urandom);
      n_clk = 14'($urandom); result_ready = 1'($urandom);
      tick();
      vectors++;
      if ({code_out, enable_out, busy, result_valid, result_code, result_nclk, done, aborted} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got code=%0h en=%b busy=%b valid=%b rcode=%0h rnclk=%0d done=%b ab=%b, expected all 0",
                 code_out, enable_out, busy, result_valid, result_code, result_nclk, done, aborted);
      end
    end
    cal_start = 0; result_ready = 0; nrst = 1; lut_state = 7'h2A; lut_enable = 1;
    tick();
    vectors++;
    if (code_out !== 7'h2A || enable_out !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_passthrough: got code=%0h en=%b busy=%b, expected code=2a en=1 busy=0", code_out, enable_out, busy);
    end
  endtask

  task automatic test_sweep(input logic [6:0] first, input logic [6:0] last, input logic [15:0] dwell, input string name);
    int low, cyc, ncodes, dwell_eff;
    logic [6:0] code;
    dwell_eff = (dwell == 0) ? 1 : int'(dwell);
    ncodes = (first <= last) ? int'(last) - int'(first) + 1 : int'(first) - int'(last) + 1;
    n_clk = 14'd1000; result_ready = 1;
    code_first = first; code_last = last; dwell_cycles = dwell; cal_start = 1;
    tick();
    cal_start = 0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_busy: got %b, expected 1", name, busy);
    end
    code = first;
    for (int k = 0; k < ncodes; k++) begin
      low = 0;
      while (enable_out === 1'b0 && low < 200) begin
        vectors++;
        if (code_out !== code) begin
          miscompares++;
          $display("FAIL %s_settle_code: got %0d, expected %0d", name, code_out, code);
        end
        low++;
        tick();
      end
      vectors++;
      if (low != 64) begin
        miscompares++;
        $display("FAIL %s_settle_len: got %0d cycles, expected 64", name, low);
      end
      cyc = 0;
      while (result_valid !== 1'b1 && cyc < 2000) begin
        cyc++;
        tick();
      end
      vectors++;
      if (cyc != dwell_eff * 4) begin
        miscompares++;
        $display("FAIL %s_accum_len: got %0d cycles, expected %0d", name, cyc, dwell_eff * 4);
      end
      vectors++;
      if (result_code !== code || result_nclk !== 14'd1000 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_result: got code=%0d nclk=%0d done=%b, expected code=%0d nclk=1000 done=0",
                 name, result_code, result_nclk, done, code);
      end
      tick();
      if (k == ncodes - 1) begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0 || result_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_done: got done=%b busy=%b aborted=%b valid=%b, expected 1 0 0 0", name, done, busy, aborted, result_valid);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_done_pulse: got %b one cycle later, expected 0", name, done);
        end
      end else begin
        code = (first <= last) ? code + 7'd1 : code - 7'd1;
        vectors++;
        if (result_valid !== 1'b0 || code_out !== code) begin
          miscompares++;
          $display("FAIL %s_step: got valid=%b code=%0d, expected valid=0 code=%0d", name, result_valid, code_out, code);
        end
      end
    end
  endtask

  task automatic test_averaging();
    logic [13:0] samp [3][4];
    logic [13:0] exp_avg [3];
    int low, cyc;
    samp[0] = '{14'd1000, 14'd1001, 14'd1001, 14'd1001}; exp_avg[0] = 14'd1000;
    samp[1] = '{14'd1000, 14'd1004, 14'd1000, 14'd1004}; exp_avg[1] = 14'd1002;
    samp[2] = '{14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF}; exp_avg[2] = 14'h3FFF;
    result_ready = 1;
    for (int s = 0; s < 3; s++) begin
      code_first = 7'd20; code_last = 7'd20; dwell_cycles = 16'd1; cal_start = 1;
      tick();
      cal_start = 0;
      low = 0;
      while (enable_out === 1'b0 && low < 200) begin
        low++;
        tick();
      end
      for (int j = 0; j < 4; j++) begin
        n_clk = samp[s][j];
        tick();
      end
      cyc = 0;
      while (result_valid !== 1'b1 && cyc < 50) begin
        cyc++;
        tick();
      end
      vectors++;
      if (cyc != 0 || result_nclk !== exp_avg[s] || result_code !== 7'd20) begin
        miscompares++;
        $display("FAIL avg_set%0d: got nclk=%0d code=%0d extra_wait=%0d, expected nclk=%0d code=20 extra_wait=0",
                 s, result_nclk, result_code, cyc, exp_avg[s]);
      end
      tick();
      tick();
    end
    n_clk = 14'd1000;
  endtask

  task automatic test_backpressure_abort();
    int low, cyc;
    n_clk = 14'd1000; result_ready = 0;
    code_first = 7'd30; code_last = 7'd40; dwell_cycles = 16'd2; cal_start = 1;
    tick();
    cal_start = 0;
    low = 0;
    while (enable_out === 1'b0 && low < 200) begin
      if (low == 5) begin
        cal_start = 1; code_first = 7'd99; code_last = 7'd0; dwell_cycles = 16'd7;
      end else cal_start = 0;
      vectors++;
      if (code_out !== 7'd30) begin
        miscompares++;
        $display("FAIL bp_start_ignored: got code=%0d, expected 30", code_out);
      end
      low++;
      tick();
    end
    cal_start = 0;
    vectors++;
    if (low != 64) begin
      miscompares++;
      $display("FAIL bp_settle_len: got %0d, expected 64", low);
    end
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 2000) begin
      cyc++;
      tick();
    end
    vectors++;
    if (cyc != 8) begin
      miscompares++;
      $display("FAIL bp_accum_len: got %0d cycles, expected 8", cyc);
    end
    n_clk = 14'd5;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (result_valid !== 1'b1 || result_code !== 7'd30 || result_nclk !== 14'd1000 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid=%b code=%0d nclk=%0d busy=%b, expected 1 30 1000 1",
                 i, result_valid, result_code, result_nclk, busy);
      end
    end
    cal_abort = 1; lut_state = 7'h11; lut_enable = 0;
    tick();
    cal_abort = 0;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_effect: got busy=%b valid=%b aborted=%b done=%b, expected 0 0 1 0", busy, result_valid, aborted, done);
    end
    lut_state = 7'h22; lut_enable = 1;
    tick();
    vectors++;
    if (aborted !== 1'b0 || done !== 1'b0 || code_out !== 7'h22 || enable_out !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_after: got aborted=%b done=%b code=%0h en=%b, expected 0 0 22 1", aborted, done, code_out, enable_out);
    end
    n_clk = 14'd1000;
  endtask

  task automatic test_abort_idle();
    lut_state = 7'h33; lut_enable = 1; cal_start = 1; cal_abort = 1; code_first = 7'd1; code_last = 7'd2;
    tick();
    cal_start = 0;
    tick();
    cal_abort = 0;
    vectors++;
    if (busy !== 1'b0 || aborted !== 1'b0 || code_out !== 7'h33 || enable_out !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b aborted=%b code=%0h en=%b, expected 0 0 33 1", busy, aborted, code_out, enable_out);
    end
  endtask

  task automatic test_reset_midsweep();
    code_first = 7'd50; code_last = 7'd52; dwell_cycles = 16'd3; result_ready = 1; cal_start = 1;
    tick();
    cal_start = 0;
    for (int i = 0; i < 10; i++) tick();
    #2 nrst = 0;
    #1;
    vectors++;
    if ({code_out, enable_out, busy, result_valid, done, aborted} !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got code=%0d en=%b busy=%b valid=%b done=%b ab=%b, expected all 0",
               code_out, enable_out, busy, result_valid, done, aborted);
    end
    tick();
    nrst = 1; lut_state = 7'h15; lut_enable = 1;
    tick();
    vectors++;
    if (code_out !== 7'h15 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: got code=%0h busy=%b done=%b ab=%b, expected 15 0 0 0", code_out, busy, done, aborted);
    end
  endtask

  initial begin
    test_reset();
    test_sweep(7'd5, 7'd5, 16'd4, "single");
    test_sweep(7'd3, 7'd6, 16'd4, "ascend");
    test_sweep(7'd10, 7'd8, 16'd0, "descend");
    test_averaging();
    test_backpressure_abort();
    test_abort_idle();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
